// File: rtl/ifft4_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ifft4_stream
// Purpose  : Sequential 4-point radix-2 inverse FFT. Loads one frame of four
//            complex Q1.(W-1) samples, runs two time-multiplexed butterfly
//            stages (one butterfly pair per cycle, per-stage 1/2 scaling with
//            round-half-up and saturation), then streams x[0..3] out.
// Revision : 1.0 - initial release
// ============================================================================
module ifft4_stream #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_re,
    input  logic [BIT_WIDTH-1:0] in_im,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_re,
    output logic [BIT_WIDTH-1:0] out_im,
    output logic                 out_last,
    output logic                 busy,
    output logic                 frame_err
);

    localparam logic signed [BIT_WIDTH+1:0] C_ONE = 1;
    localparam logic signed [BIT_WIDTH+1:0] C_MAX = (2 ** (BIT_WIDTH - 1)) - 1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Scaled add: (a +/- b) in W+1 bits, then (s+1)>>>1; only the top can overflow.
    function automatic logic [BIT_WIDTH-1:0] sa(input logic [BIT_WIDTH-1:0] a,
                                                input logic [BIT_WIDTH-1:0] b,
                                                input logic                 sub);
        logic signed [BIT_WIDTH:0]   ea;
        logic signed [BIT_WIDTH:0]   eb;
        logic signed [BIT_WIDTH:0]   s;
        logic signed [BIT_WIDTH+1:0] t;
        ea = $signed({a[BIT_WIDTH-1], a});
        eb = $signed({b[BIT_WIDTH-1], b});
        s  = sub ? (ea - eb) : (ea + eb);
        t  = $signed({s[BIT_WIDTH], s}) + C_ONE;
        t  = t >>> 1;
        if (t > C_MAX) begin
            sa = C_MAX[BIT_WIDTH-1:0];
        end else begin
            sa = t[BIT_WIDTH-1:0];
        end
    endfunction

    state_t               state_q;
    logic                 phase_q;
    logic [1:0]           beat_q;
    logic [1:0]           cnt_q;
    logic [BIT_WIDTH-1:0] x_re_q [4];
    logic [BIT_WIDTH-1:0] x_im_q [4];
    logic [BIT_WIDTH-1:0] a_re_q [4];
    logic [BIT_WIDTH-1:0] a_im_q [4];
    logic [BIT_WIDTH-1:0] y_re_q [4];
    logic [BIT_WIDTH-1:0] y_im_q [4];

    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [BIT_WIDTH-1:0] out_re_q;
    logic [BIT_WIDTH-1:0] out_im_q;
    logic                 out_last_q;
    logic                 busy_q;
    logic                 frame_err_q;

    logic [BIT_WIDTH-1:0] op_a_re_d, op_a_im_d, op_b_re_d, op_b_im_d;
    logic                 flip_d;
    logic [BIT_WIDTH-1:0] bf_p_re_d, bf_p_im_d, bf_m_re_d, bf_m_im_d;

    // Shared butterfly: select operands for the current stage/phase. For the
    // +j twiddle, b carries (A3im, A3re) and the real add/sub is swapped,
    // which avoids negating A3im (and its -2^(W-1) overflow).
    always_comb begin
        op_a_re_d = '0;
        op_a_im_d = '0;
        op_b_re_d = '0;
        op_b_im_d = '0;
        flip_d    = 1'b0;
        case (state_q)
            ST_S1: begin
                if (!phase_q) begin
                    op_a_re_d = x_re_q[0]; op_a_im_d = x_im_q[0];
                    op_b_re_d = x_re_q[2]; op_b_im_d = x_im_q[2];
                end else begin
                    op_a_re_d = x_re_q[1]; op_a_im_d = x_im_q[1];
                    op_b_re_d = x_re_q[3]; op_b_im_d = x_im_q[3];
                end
            end
            ST_S2: begin
                if (!phase_q) begin
                    op_a_re_d = a_re_q[0]; op_a_im_d = a_im_q[0];
                    op_b_re_d = a_re_q[2]; op_b_im_d = a_im_q[2];
                end else begin
                    op_a_re_d = a_re_q[1]; op_a_im_d = a_im_q[1];
                    op_b_re_d = a_im_q[3]; op_b_im_d = a_re_q[3];
                    flip_d    = 1'b1;
                end
            end
            default: ;
        endcase
        bf_p_re_d = sa(op_a_re_d, op_b_re_d, flip_d);
        bf_p_im_d = sa(op_a_im_d, op_b_im_d, 1'b0);
        bf_m_re_d = sa(op_a_re_d, op_b_re_d, ~flip_d);
        bf_m_im_d = sa(op_a_im_d, op_b_im_d, 1'b1);
    end

    // Control FSM plus sample/intermediate/output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            phase_q     <= 1'b0;
            beat_q      <= 2'd0;
            cnt_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                x_re_q[i] <= '0; x_im_q[i] <= '0;
                a_re_q[i] <= '0; a_im_q[i] <= '0;
                y_re_q[i] <= '0; y_im_q[i] <= '0;
            end
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        x_re_q[beat_q] <= in_re;
                        x_im_q[beat_q] <= in_im;
                        if (beat_q == 2'd3) begin
                            // Full frame: processed even if in_last is missing.
                            state_q     <= ST_S1;
                            beat_q      <= 2'd0;
                            phase_q     <= 1'b0;
                            in_ready_q  <= 1'b0;
                            busy_q      <= 1'b1;
                            frame_err_q <= ~in_last;
                        end else if (in_last) begin
                            // Early in_last: drop the partial frame.
                            beat_q      <= 2'd0;
                            frame_err_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end
                end
                ST_S1: begin
                    phase_q <= ~phase_q;
                    if (!phase_q) begin
                        a_re_q[0] <= bf_p_re_d; a_im_q[0] <= bf_p_im_d;
                        a_re_q[1] <= bf_m_re_d; a_im_q[1] <= bf_m_im_d;
                    end else begin
                        a_re_q[2] <= bf_p_re_d; a_im_q[2] <= bf_p_im_d;
                        a_re_q[3] <= bf_m_re_d; a_im_q[3] <= bf_m_im_d;
                        state_q   <= ST_S2;
                    end
                end
                ST_S2: begin
                    phase_q <= ~phase_q;
                    if (!phase_q) begin
                        y_re_q[0] <= bf_p_re_d; y_im_q[0] <= bf_p_im_d;
                        y_re_q[2] <= bf_m_re_d; y_im_q[2] <= bf_m_im_d;
                    end else begin
                        y_re_q[1]   <= bf_p_re_d; y_im_q[1] <= bf_p_im_d;
                        y_re_q[3]   <= bf_m_re_d; y_im_q[3] <= bf_m_im_d;
                        out_re_q    <= y_re_q[0];
                        out_im_q    <= y_im_q[0];
                        out_last_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        cnt_q       <= 2'd0;
                        state_q     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_valid_q && out_ready) begin
                        if (cnt_q == 2'd3) begin
                            state_q     <= ST_LOAD;
                            out_valid_q <= 1'b0;
                            out_re_q    <= '0;
                            out_im_q    <= '0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            cnt_q       <= 2'd0;
                        end else begin
                            cnt_q      <= cnt_q + 2'd1;
                            out_re_q   <= y_re_q[cnt_q + 2'd1];
                            out_im_q   <= y_im_q[cnt_q + 2'd1];
                            out_last_q <= (cnt_q == 2'd2);
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ifft4_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ifft4_stream
// Purpose  : Self-checking bench for ifft4_stream against an arithmetic
//            reference of the scaled 4-point inverse DFT butterflies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifft4_stream;
    localparam int W    = 8;
    localparam int MAXV = (2 ** (W - 1)) - 1;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_re;
    logic [W-1:0] in_im;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic         out_last;
    logic         busy;
    logic         frame_err;

    int errors = 0;
    int checks = 0;

    int   m_xr [4];
    int   m_xi [4];
    int   e_re [4];
    int   e_im [4];
    int   got_re [4];
    int   got_im [4];
    logic got_last [4];
    int   got_n;

    ifft4_stream #(.BIT_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last),
        .busy(busy), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Halve with round-half-up and clip at the positive limit.
    function automatic int ref_sa(input int v);
        int r;
        r = (v + 1) >>> 1;
        if (r > MAXV) r = MAXV;
        return r;
    endfunction

    // Reference: x = (1/4) * IDFT4(X), done as two halving radix-2 stages.
    function automatic void ref_model();
        int a0r, a0i, a1r, a1i, a2r, a2i, a3r, a3i;
        a0r = ref_sa(m_xr[0] + m_xr[2]); a0i = ref_sa(m_xi[0] + m_xi[2]);
        a1r = ref_sa(m_xr[0] - m_xr[2]); a1i = ref_sa(m_xi[0] - m_xi[2]);
        a2r = ref_sa(m_xr[1] + m_xr[3]); a2i = ref_sa(m_xi[1] + m_xi[3]);
        a3r = ref_sa(m_xr[1] - m_xr[3]); a3i = ref_sa(m_xi[1] - m_xi[3]);
        e_re[0] = ref_sa(a0r + a2r); e_im[0] = ref_sa(a0i + a2i);
        e_re[2] = ref_sa(a0r - a2r); e_im[2] = ref_sa(a0i - a2i);
        e_re[1] = ref_sa(a1r - a3i); e_im[1] = ref_sa(a1i + a3r);
        e_re[3] = ref_sa(a1r + a3i); e_im[3] = ref_sa(a1i - a3r);
    endfunction

    function automatic void set_frame(input int r0, input int i0, input int r1, input int i1,
                                      input int r2, input int i2, input int r3, input int i3);
        m_xr[0] = r0; m_xi[0] = i0; m_xr[1] = r1; m_xi[1] = i1;
        m_xr[2] = r2; m_xi[2] = i2; m_xr[3] = r3; m_xi[3] = i3;
        ref_model();
    endfunction

    // Present one beat at a negedge and return at the negedge after its handshake.
    task automatic drive_beat(input int re, input int im, input bit last);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL drive_timeout in_ready=%0b required=1", in_ready);
        end
        in_valid = 1'b1;
        in_re    = re[W-1:0];
        in_im    = im[W-1:0];
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input bit last3);
        for (int i = 0; i < 4; i++) drive_beat(m_xr[i], m_xi[i], (i == 3) ? last3 : 1'b0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Capture up to four output handshakes, optionally with random stalls.
    task automatic collect(input bit rand_ready);
        got_n = 0;
        for (int cyc = 0; cyc < 300 && got_n < 4; cyc++) begin
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid && out_ready) begin
                got_re[got_n]   = $signed(out_re);
                got_im[got_n]   = $signed(out_im);
                got_last[got_n] = out_last;
                got_n++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%0b vld=%0b busy=%0b ferr=%0b required 1 0 0 0",
                     in_ready, out_valid, busy, frame_err);
        end
        checks++;
        if (out_re !== '0 || out_im !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got re=%0d im=%0d last=%0b required 0 0 0", out_re, out_im, out_last);
        end
    endtask

    task automatic test_impulse();
        int lat;
        set_frame(64, 0, 0, 0, 0, 0, 0, 0);
        send_frame(1'b1);
        wait_valid(lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL impulse_latency got=%0d required=4", lat);
        end
        collect(1'b0);
        checks++;
        if (got_n !== 4) begin errors++; $display("FAIL impulse_count got=%0d required=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== 16 || got_im[i] !== 0 || got_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL impulse_x%0d got=(%0d,%0d,last=%0b) required=(16,0,last=%0b)",
                         i, got_re[i], got_im[i], got_last[i], (i == 3));
            end
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL impulse_return got rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_tone();
        int xr_req [4];
        int xi_req [4];
        xr_req[0] = 16; xr_req[1] = 0;  xr_req[2] = -16; xr_req[3] = 0;
        xi_req[0] = 0;  xi_req[1] = 16; xi_req[2] = 0;   xi_req[3] = -16;
        set_frame(0, 0, 64, 0, 0, 0, 0, 0);
        send_frame(1'b1);
        collect(1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== xr_req[i] || got_im[i] !== xi_req[i]) begin
                errors++;
                $display("FAIL tone_x%0d got=(%0d,%0d) required=(%0d,%0d)",
                         i, got_re[i], got_im[i], xr_req[i], xi_req[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int xr_req [4];
        xr_req[0] = 0; xr_req[1] = 64; xr_req[2] = 0; xr_req[3] = 64;
        set_frame(127, 0, 0, 0, -128, 0, 0, 0);
        send_frame(1'b1);
        collect(1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== xr_req[i] || got_im[i] !== 0) begin
                errors++;
                $display("FAIL sat_x%0d got=(%0d,%0d) required=(%0d,0)", i, got_re[i], got_im[i], xr_req[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        set_frame(37, -5, -90, 12, 100, -128, 3, 77);
        send_frame(1'b1);
        out_ready = 1'b1;
        wait_valid(lat);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ($signed(out_re) !== e_re[i] || $signed(out_im) !== e_im[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_x%0d got=(%0d,%0d) required=(%0d,%0d)",
                         i, $signed(out_re), $signed(out_im), e_re[i], e_im[i]);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ($signed(out_re) !== e_re[2] || $signed(out_im) !== e_im[2] || out_valid !== 1'b1 ||
                out_last !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall%0d got=(%0d,%0d) vld=%0b last=%0b rdy=%0b busy=%0b required=(%0d,%0d) 1 0 0 1",
                         c, $signed(out_re), $signed(out_im), out_valid, out_last, in_ready, busy, e_re[2], e_im[2]);
            end
            if (c < 3) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ($signed(out_re) !== e_re[3] || $signed(out_im) !== e_im[3] || out_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_x3 got=(%0d,%0d,last=%0b) required=(%0d,%0d,last=1)",
                     $signed(out_re), $signed(out_im), out_last, e_re[3], e_im[3]);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_return got rdy=%0b vld=%0b busy=%0b required 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_framing();
        bit seen;
        int lat;
        drive_beat(10, 10, 1'b0);
        drive_beat(20, 20, 1'b1);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_early_pulse got=%0b required=1", frame_err); end
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_pulse_width got=%0b required=0", frame_err); end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid || !in_ready) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL frame_discard got activity=%0b required=0", seen); end
        set_frame(64, 0, 0, 0, 0, 0, 0, 0);
        send_frame(1'b1);
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_good_err got=%0b required=0", frame_err); end
        collect(1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== 16 || got_im[i] !== 0) begin
                errors++;
                $display("FAIL frame_after_x%0d got=(%0d,%0d) required=(16,0)", i, got_re[i], got_im[i]);
            end
        end
        set_frame(-50, 20, 8, -8, 30, 1, -127, 64);
        send_frame(1'b0);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_nolast_pulse got=%0b required=1", frame_err); end
        wait_valid(lat);
        collect(1'b0);
        checks++;
        if (got_n !== 4) begin errors++; $display("FAIL frame_nolast_count got=%0d required=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== e_re[i] || got_im[i] !== e_im[i]) begin
                errors++;
                $display("FAIL frame_nolast_x%0d got=(%0d,%0d) required=(%0d,%0d)",
                         i, got_re[i], got_im[i], e_re[i], e_im[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) begin
                m_xr[i] = (f == 7) ? ((i % 2 == 0) ? 127 : -128) : int'($urandom_range(0, 255)) - 128;
                m_xi[i] = (f == 7) ? ((i < 2) ? -128 : 127)      : int'($urandom_range(0, 255)) - 128;
            end
            ref_model();
            send_frame(1'b1);
            collect(1'b1);
            checks++;
            if (got_n !== 4) begin errors++; $display("FAIL rand%0d_count got=%0d required=4", f, got_n); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_re[i] !== e_re[i] || got_im[i] !== e_im[i] || got_last[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL rand%0d_x%0d got=(%0d,%0d,last=%0b) required=(%0d,%0d,last=%0b)",
                             f, i, got_re[i], got_im[i], got_last[i], e_re[i], e_im[i], (i == 3));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_frame(55, -33, 12, 99, -7, 0, 80, -60);
        send_frame(1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got=%0b required=1", busy); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_immediate got vld=%0b busy=%0b rdy=%0b required 0 0 1", out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_frame(64, 0, 0, 0, 0, 0, 0, 0);
        send_frame(1'b1);
        collect(1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== 16 || got_im[i] !== 0) begin
                errors++;
                $display("FAIL midrst_after_x%0d got=(%0d,%0d) required=(16,0)", i, got_re[i], got_im[i]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_tone();
        test_saturation();
        test_backpressure();
        test_framing();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
